rd_req_splitter: RTL

//  Read-side command stage feeding the AXI master wrapper's rd_req/rd_ready/rd_addr/rd_req_size port.

---
 rtl/rd_req_splitter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/rd_req_splitter.sv
// Read-side command stage: splits one strided block-read command into AXI read
// requests of at most MAX_TX_SIZE beats that never cross a 4KB page, then counts
// returned beats and pulses done once the whole block has landed in the inbuf.
module rd_req_splitter #(
   parameter int unsigned ADDR_W        = 32,
   parameter int unsigned AXI_DATA_W    = 64,
   parameter int unsigned TX_SIZE_WIDTH = 10,
   parameter int unsigned MAX_TX_SIZE   = 256,
   parameter int unsigned WORDS_W       = 16,
   parameter int unsigned ROWS_W        = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [ADDR_W-1:0]        cmd_addr,
   input  logic [WORDS_W-1:0]       cmd_words,
   input  logic [ROWS_W-1:0]        cmd_rows,
   input  logic [ADDR_W-1:0]        cmd_stride,
   output logic                     rd_req,
   input  logic                     rd_ready,
   output logic [ADDR_W-1:0]        rd_addr,
   output logic [TX_SIZE_WIDTH-1:0] rd_req_size,
   input  logic                     inbuf_push,
   output logic                     busy,
   output logic                     done
);

   localparam int unsigned BYTES      = AXI_DATA_W / 8;
   localparam int unsigned LOG2B      = $clog2(BYTES);
   localparam int unsigned PAGE_BEATS = 4096 / BYTES;
   localparam int unsigned PAGE_W     = $clog2(PAGE_BEATS + 1);
   localparam int unsigned TOT_W      = ROWS_W + WORDS_W;
   localparam int unsigned BW0        = (WORDS_W > TX_SIZE_WIDTH) ? WORDS_W : TX_SIZE_WIDTH;
   localparam int unsigned BW1        = (PAGE_W > BW0) ? PAGE_W : BW0;
   // Beat arithmetic width: one bit of headroom over every beat-count operand
   localparam int unsigned BW         = BW1 + 1;
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CALC  = 3'd1;
   localparam logic [2:0] S_ISSUE = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]               state,       state_n;
   logic [ADDR_W-1:0]        row_base,    row_base_n;
   logic [ADDR_W-1:0]        cur_addr,    cur_addr_n;
   logic [ADDR_W-1:0]        stride_q,    stride_q_n;
   logic [WORDS_W-1:0]       words_q,     words_q_n;
   logic [WORDS_W-1:0]       row_rem,     row_rem_n;
   logic [ROWS_W-1:0]        rows_left,   rows_left_n;
   logic [TOT_W-1:0]         total,       total_n;
   logic [TOT_W-1:0]         rx_count,    rx_count_n;
   logic                     rd_req_n;
   logic [ADDR_W-1:0]        rd_addr_n;
   logic [TX_SIZE_WIDTH-1:0] rd_req_size_n;
   logic                     busy_n;
   logic                     done_n;
   logic                     cmd_ready_n;

   logic [11:0]              page_off;
   logic [BW-1:0]            page_left;
   logic [BW-1:0]            chunk_c;
   logic [BW-1:0]            rem_after;
   logic [ADDR_W-1:0]        next_row;
   logic [TOT_W-1:0]         cmd_total;
   logic                     in_cmd;

   // Chunk size for the next request: row remainder, max burst and 4KB page room
   always_comb begin
      page_off  = cur_addr[11:0] >> LOG2B;
      page_left = BW'(PAGE_BEATS) - BW'(page_off);
      chunk_c   = BW'(row_rem);
      if (BW'(MAX_TX_SIZE) < chunk_c) chunk_c = BW'(MAX_TX_SIZE);
      if (page_left < chunk_c)        chunk_c = page_left;
   end

   // Next-state and next-register values
   always_comb begin
      state_n       = state;
      row_base_n    = row_base;
      cur_addr_n    = cur_addr;
      stride_q_n    = stride_q;
      words_q_n     = words_q;
      row_rem_n     = row_rem;
      rows_left_n   = rows_left;
      total_n       = total;
      rx_count_n    = rx_count;
      rd_addr_n     = rd_addr;
      rd_req_size_n = rd_req_size;
      rem_after     = BW'(row_rem) - BW'(rd_req_size);
      next_row      = row_base + stride_q;
      cmd_total     = TOT_W'(cmd_words) * TOT_W'(cmd_rows);
      in_cmd        = (state == S_CALC) || (state == S_ISSUE) || (state == S_DRAIN);

      // returned beats count only while a command is in flight, saturating at total
      if (in_cmd && inbuf_push && (rx_count != total)) rx_count_n = rx_count + TOT_W'(1);

      case (state)
         S_IDLE: begin
            if (cmd_valid) begin
               row_base_n  = cmd_addr & ALIGN_MASK;
               cur_addr_n  = cmd_addr & ALIGN_MASK;
               stride_q_n  = cmd_stride;
               words_q_n   = cmd_words;
               row_rem_n   = cmd_words;
               rows_left_n = cmd_rows;
               total_n     = cmd_total;
               rx_count_n  = '0;
               state_n     = (cmd_total == '0) ? S_DRAIN : S_CALC;
            end
         end
         S_CALC: begin
            rd_addr_n     = cur_addr;
            rd_req_size_n = TX_SIZE_WIDTH'(chunk_c);
            state_n       = S_ISSUE;
         end
         S_ISSUE: begin
            if (rd_ready) begin
               if (rem_after == '0) begin
                  row_base_n  = next_row;
                  cur_addr_n  = next_row;
                  row_rem_n   = words_q;
                  rows_left_n = rows_left - ROWS_W'(1);
                  state_n     = (rows_left == ROWS_W'(1)) ? S_DRAIN : S_CALC;
               end else begin
                  cur_addr_n  = cur_addr + (ADDR_W'(rd_req_size) << LOG2B);
                  row_rem_n   = WORDS_W'(rem_after);
                  state_n     = S_CALC;
               end
            end
         end
         S_DRAIN: begin
            if (rx_count == total) state_n = S_DONE;
         end
         S_DONE: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase

      rd_req_n    = (state_n == S_ISSUE);
      busy_n      = (state_n == S_CALC) || (state_n == S_ISSUE) || (state_n == S_DRAIN);
      done_n      = (state_n == S_DONE);
      cmd_ready_n = (state_n == S_IDLE);
   end

   // State, datapath and registered outputs with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= S_IDLE;
         row_base    <= '0;
         cur_addr    <= '0;
         stride_q    <= '0;
         words_q     <= '0;
         row_rem     <= '0;
         rows_left   <= '0;
         total       <= '0;
         rx_count    <= '0;
         rd_req      <= 1'b0;
         rd_addr     <= '0;
         rd_req_size <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         cmd_ready   <= 1'b1;
      end else begin
         state       <= state_n;
         row_base    <= row_base_n;
         cur_addr    <= cur_addr_n;
         stride_q    <= stride_q_n;
         words_q     <= words_q_n;
         row_rem     <= row_rem_n;
         rows_left   <= rows_left_n;
         total       <= total_n;
         rx_count    <= rx_count_n;
         rd_req      <= rd_req_n;
         rd_addr     <= rd_addr_n;
         rd_req_size <= rd_req_size_n;
         busy        <= busy_n;
         done        <= done_n;
         cmd_ready   <= cmd_ready_n;
      end
   end

endmodule
